// File: rtl/led_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_flow_ctrl : prescaled one-cold 8-LED sequencer (hold/fwd/rev/bounce)  |
// | Option LED_FLOW_BLINK_EN: mode 11 blinks all LEDs instead of bouncing.    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module led_flow_ctrl #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sw,
  output logic [2:0] idx,
  output logic [7:0] led,
  output logic       step
);

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0]       MODE_FWD   = 2'b01;
  localparam logic [1:0]       MODE_REV   = 2'b10;
  localparam logic [1:0]       MODE_SPCL  = 2'b11;
  localparam logic [CNT_W-1:0] C_TICK_DIV = CNT_W'(TICK_DIV);

  logic [4:0]       sw_meta_q, sw_sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             dir_up_q, dir_up_d;
  logic             step_q, step_d;

  logic             run_en;
  logic [1:0]       mode;
  logic [CNT_W-1:0] period_m1;
  logic             terminal;

  assign run_en    = sw_sync_q[0];
  assign mode      = sw_sync_q[2:1];
  assign period_m1 = (C_TICK_DIV >> sw_sync_q[4:3]) - CNT_W'(1);
  // ">=" so a mid-count speed increase fires next cycle instead of wrapping
  assign terminal  = (cnt_q >= period_m1);

`ifdef LED_FLOW_BLINK_EN
  logic blink_on_q, blink_on_d;
  logic blink_off_q, blink_off_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dir_up_d = dir_up_q;
    step_d   = 1'b0;
`ifdef LED_FLOW_BLINK_EN
    blink_on_d  = blink_on_q;
    blink_off_d = blink_off_q;
`endif
    if (state_q == ST_STOP) begin
      cnt_d = '0;
      if (run_en) state_d = ST_RUN;
    end else if (!run_en) begin
      state_d = ST_STOP;
      cnt_d   = '0;
    end else if (terminal) begin
      cnt_d  = '0;
      step_d = 1'b1;
      case (mode)
        MODE_FWD: idx_d = idx_q + 3'd1;
        MODE_REV: idx_d = idx_q - 3'd1;
        MODE_SPCL: begin
`ifdef LED_FLOW_BLINK_EN
          if (!blink_on_q) begin
            blink_on_d  = 1'b1;
            blink_off_d = 1'b0;
          end else begin
            blink_off_d = ~blink_off_q;
          end
`else
          if (dir_up_q) begin
            if (idx_q == 3'd7) begin
              dir_up_d = 1'b0;
              idx_d    = 3'd6;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            if (idx_q == 3'd0) begin
              dir_up_d = 1'b1;
              idx_d    = 3'd1;
            end else begin
              idx_d = idx_q - 3'd1;
            end
          end
`endif
        end
        default: ;
      endcase
`ifdef LED_FLOW_BLINK_EN
      if (mode != MODE_SPCL) blink_on_d = 1'b0;
`endif
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      state_q   <= ST_STOP;
      cnt_q     <= '0;
      idx_q     <= '0;
      dir_up_q  <= 1'b1;
      step_q    <= 1'b0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dir_up_q  <= dir_up_d;
      step_q    <= step_d;
    end
  end

`ifdef LED_FLOW_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_on_q  <= 1'b0;
      blink_off_q <= 1'b0;
    end else begin
      blink_on_q  <= blink_on_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign led = blink_on_q ? {8{blink_off_q}} : ~(8'h80 >> idx_q);
`else
  assign led = ~(8'h80 >> idx_q);
`endif

  assign idx  = idx_q;
  assign step = step_q;

endmodule
`default_nettype wire

// File: tb/tb_led_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_flow_ctrl : scoreboard bench for led_flow_ctrl (TICK_DIV = 8)      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_led_flow_ctrl;

  localparam int TD = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sw    = 5'b00011;
  logic [2:0] idx;
  logic [7:0] led;
  logic       step;

  led_flow_ctrl #(.TICK_DIV(TD), .CNT_W(26)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .idx  (idx),
    .led  (led),
    .step (step)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         stamp;
    logic [2:0] idx;
    logic [7:0] led;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int errors  = 0;

  // Reference model state (behavioural)
  logic [4:0] m_meta, m_sync;
  bit         m_run, m_up, m_bon, m_boff;
  int         m_cnt, m_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] model_led();
    if (m_bon) return m_boff ? 8'hFF : 8'h00;
    return 8'hFF ^ (8'd1 << (7 - m_idx));
  endfunction

  task automatic model_reset();
    m_meta = '0; m_sync = '0; m_run = 0; m_up = 1;
    m_bon = 0; m_boff = 0; m_cnt = 0; m_idx = 0;
  endtask

  // Predicts what the coming rising edge does, given sw held across it
  task automatic model_edge(input logic [4:0] v);
    exp_t e;
    int   p, nxt;
    p = TD >> m_sync[4:3];
    if (!m_run) begin
      m_cnt = 0;
      m_run = m_sync[0];
    end else if (!m_sync[0]) begin
      m_run = 0;
      m_cnt = 0;
    end else if (m_cnt >= p - 1) begin
      m_cnt = 0;
      case (m_sync[2:1])
        2'b01: m_idx = (m_idx + 1) % 8;
        2'b10: m_idx = (m_idx + 7) % 8;
        2'b11: begin
`ifdef LED_FLOW_BLINK_EN
          if (!m_bon) begin m_bon = 1; m_boff = 0; end
          else m_boff = !m_boff;
`else
          nxt = m_up ? m_idx + 1 : m_idx - 1;
          if (nxt > 7) begin m_up = 0; nxt = 6; end
          else if (nxt < 0) begin m_up = 1; nxt = 1; end
          m_idx = nxt;
`endif
        end
        default: ;
      endcase
      if (m_sync[2:1] != 2'b11) m_bon = 0;
      e.stamp = edge_cnt + 1;
      e.idx   = 3'(m_idx);
      e.led   = model_led();
      exp_q.push_back(e);
    end else begin
      m_cnt++;
    end
    m_sync = m_meta;
    m_meta = v;
  endtask

  task automatic tick(input logic [4:0] v);
    @(negedge clk);
    sw = v;
    model_edge(v);
  endtask

  task automatic mid_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_idx",  {29'd0, idx}, 32'd0);
    chk("async_rst_led",  {24'd0, led}, 32'h7F);
    chk("async_rst_step", {31'd0, step}, 32'd0);
    exp_q.delete();
    model_reset();
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    model_edge(sw);
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses step
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (step === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_step: got step=1 idx=%0d, expected no step (edge %0d)", idx, edge_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("step_time", edge_cnt, e.stamp);
          chk("step_idx",  {29'd0, idx}, {29'd0, e.idx});
          chk("step_led",  {24'd0, led}, {24'd0, e.led});
        end
      end else if (exp_q.size() != 0 && exp_q[0].stamp <= edge_cnt) begin
        e = exp_q.pop_front();
        vectors++;
        errors++;
        $display("FAIL missing_step: got step=0, expected step idx=%0d at edge %0d", e.idx, e.stamp);
      end
    end
  end

  initial begin
    logic [4:0] cur;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_idx",  {29'd0, idx}, 32'd0);
    chk("rst_led",  {24'd0, led}, 32'h7F);
    chk("rst_step", {31'd0, step}, 32'd0);
    rst_n = 1'b1;
    model_edge(sw);
    tick(5'b00011);
    chk("rel_idx",  {29'd0, idx}, 32'd0);
    chk("rel_led",  {24'd0, led}, 32'h7F);
    chk("rel_step", {31'd0, step}, 32'd0);

    repeat (80) tick(5'b00011);                   // forward with wrap
    repeat (5)  tick(5'b00011);
    repeat (20) tick(5'b11011);                   // speed 3 mid-count
    repeat (20) tick(5'b11101);                   // reverse, fast
    repeat (40) tick(5'b00101);
    repeat (130) tick(5'b00111);                  // bounce / blink
    repeat (30) tick(5'b00001);                   // hold: pulses, idx frozen
    repeat (20) tick(5'b00011);
    repeat (60) tick(5'b00111);
    repeat (20) tick(5'b00011);
    for (int off = 0; off < 10; off++) begin      // disable at every phase
      repeat (off + 8) tick(5'b00011);
      repeat (3) tick(5'b00010);
    end
    repeat (30) tick(5'b00011);
    mid_reset(2);
    repeat (40) tick(5'b00011);

    cur = 5'b00011;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cur    = 5'($urandom);
        cur[0] = ($urandom_range(0, 7) != 0);
      end
      tick(cur);
    end
    mid_reset(1);
    repeat (30) tick(5'b01011);

    repeat (12) tick(5'b00000);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_flow_ctrl.md
Name: led_flow_ctrl

Overview:
- Sequencer for the 8-LED one-cold display (a low bit lights its LED).
- A prescaled step tick advances a 3-bit LED index according to a switch-selected pattern mode: hold, forward, reverse or bounce.
- Outputs the index and the matching active-low 8-bit LED pattern, so it can drive the board LEDs directly or feed the 3-8 decoder stage.

Parameters:
- TICK_DIV, 25000000, base step period in clk cycles at speed 0; legal range 8 to 2^26-1.
- CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W > TICK_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sw  input  5  sw[0] run enable; sw[2:1] mode; sw[4:3] speed select
- idx  output  3  current LED index
- led  output  8  active-low LED pattern, equal to ~(8'b1000_0000 >> idx) (idx 0 gives 8'h7F, idx 7 gives 8'hFE)
- step  output  1  one-cycle pulse on each index advance

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - idx=0, led=8'h7F, step=0.
  - Direction register = up; prescaler = 0; FSM = STOP.
  - Synchroniser flops = 0.
- Input sync: sw passes a 2-flop synchroniser. Every sw effect is measured from the synchronised value (2-cycle input latency).
- Period: P = TICK_DIV >> speed, so speed 0..3 gives TICK_DIV, /2, /4, /8.
- FSM STOP:
  - Prescaler held at 0; idx holds; step=0.
  - Moves to RUN when synced sw[0]=1.
- FSM RUN:
  - Prescaler increments each cycle.
  - When prescaler >= P-1: prescaler goes to 0, step pulses, idx updates per mode.
  - Moves to STOP when synced sw[0]=0. Prescaler clears; idx keeps its value.
- The ">=" comparison covers a speed increase mid-count: the step fires on the next cycle, with no long wrap.
- Step/output timing: step, idx and led are registered and change on the same clk edge. led always decodes the registered idx (no extra latency).
- Mode 00 HOLD: step still pulses; idx unchanged.
- Mode 01 FORWARD: idx+1, wrapping 7 to 0.
- Mode 10 REVERSE: idx-1, wrapping 0 to 7.
- Mode 11 BOUNCE:
  - Direction up: idx+1; at idx=7 flip to down and step to 6.
  - Direction down: idx-1; at idx=0 flip to up and step to 1.
  - Sequence 0..7,6..1,0,1...; no endpoint is repeated.
  - Entering BOUNCE from another mode keeps the current direction register. The direction register is updated only in BOUNCE.
- Mode change: sampled at each step edge. A change between steps does not touch the prescaler.
- Simultaneous run-disable and terminal count: STOP wins; no step, idx unchanged.
- Reset asserted mid-run: all state returns to reset values immediately. After release the block starts from STOP.

Optional Feature:
- Macro: LED_FLOW_BLINK_EN.
- When defined, mode 11 becomes BLINK:
  - idx frozen.
  - led toggles between 8'h00 (all on) and 8'hFF (all off) on each step, starting with 8'h00 on the first step.
  - On leaving BLINK, led returns to the idx decode on the same edge.
- When undefined, mode 11 is BOUNCE as above and no blink register exists.

Test Plan:
- Reset check (TICK_DIV=8): assert rst_n=0 with sw=5'b00011 -> idx=0, led=8'h7F, step=0. Release and hold for 1 cycle -> outputs unchanged.
- Forward with wrap (TICK_DIV=8, sw=5'b00011): steps spaced exactly 8 cycles apart -> idx runs 1,2,...,7,0. led reaches 8'hFE at idx 7, then 8'h7F.
- Speed change (TICK_DIV=8, forward): switch sw[4:3] from 00 to 11 when the prescaler is at 5 -> step on the next cycle after the synchronised change, then steps every 1 cycle. Reverse from idx=0 -> idx 7.
- Bounce (TICK_DIV=8, sw=5'b00111 from idx=0) -> idx 1..7,6,5,4,3,2,1,0,1 with no repeated endpoints. Mode 00 mid-run -> step pulses continue, idx frozen.
- Run disable coincident with terminal count: drop sw[0] 2 cycles before terminal count -> no step pulse, idx unchanged, prescaler 0. Re-enable -> first step a full P cycles later.
- With LED_FLOW_BLINK_EN, mode 11 -> led sequence 8'h00, 8'hFF, 8'h00 on successive steps, idx unchanged. Switch to mode 01 -> led equals the idx decode on the next step edge.
